// File: rtl/multi_cycle_control_unit.sv
// Sequencing FSM for the shared multi-cycle RV32I datapath: drives the mux selects
// and write enables, and tracks the halted flag and the count of retired instructions.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IF   | fetch at PC; wait for mem_ready, then latch IR and PC <= PC+4
//  S_ID   | decode; ALUOut <= old_pc + imm; ECALL resolves here
//  S_EX   | execute; branches and jumps finish here
//  S_MEM  | load/store access at ALUOut; wait for mem_ready
//  S_WB   | register write from ALUOut or MDR
//  S_HALT | halted until reset
module multi_cycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           wd_sel,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op_sel,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   op_known;

    assign op_known = (opcode == OP_R)      || (opcode == OP_I)     ||
                      (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                      (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                      (opcode == OP_JALR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IF;
            retired_count <= '0;
            is_halted     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_halted <= (state_d == S_HALT);
            if (retire) begin
                retired_count <= retired_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                if (opcode == OP_ECALL && halt_req) begin
                    state_d = S_HALT;
                end else if (opcode == OP_ECALL || !op_known) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R, OP_I:                 state_d = S_WB;
                    OP_LOAD, OP_STORE:          state_d = S_MEM;
                    OP_BRANCH, OP_JAL, OP_JALR: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    default:                    state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Everything is held at 0 while reset is low, independent of the state register.
    always_comb begin
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        wd_sel     = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op_sel = 2'b00;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        if (reset) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_ID: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                S_EX: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a  = 2'b01;
                            alu_op_sel = 2'b10;
                        end
                        OP_I: begin
                            alu_src_a  = 2'b01;
                            alu_src_b  = 2'b10;
                            alu_op_sel = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b10;
                        end
                        OP_BRANCH: begin
                            alu_src_a  = 2'b01;
                            alu_op_sel = 2'b01;
                            pc_write   = bcond;
                            pc_source  = bcond;
                        end
                        OP_JAL: begin
                            reg_write = 1'b1;
                            wd_sel    = 2'b10;
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                        end
                        // Link value is the PC before this edge, which is already old_pc+4.
                        OP_JALR: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b10;
                            reg_write = 1'b1;
                            wd_sel    = 2'b10;
                            pc_write  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode == OP_STORE);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wd_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- FSM controller that sequences a shared multi-cycle RV32I datapath in the CPU top level.
- The datapath has one ALU, one unified memory with a ready handshake, IR/MDR/A/B/ALUOut registers and an old_pc register.
- Each instruction's IF/ID/EX/MEM/WB steps are issued over several cycles.
- The unit also produces is_halted and a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of retired_count.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
opcode  input  7  IR[6:0]
bcond  input  1  ALU branch-condition result, valid in EX
mem_ready  input  1  memory done: read data valid / write accepted this cycle
halt_req  input  1  datapath reports x17 == 10, valid in ID
ir_write  output  1  latch instruction word and old_pc <= PC
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
wd_sel  output  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC
reg_write  output  1  register-file write enable
alu_src_a  output  2  00 = PC, 01 = A, 10 = old_pc
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = imm
alu_op_sel  output  2  00 = add, 01 = branch compare (funct3), 10 = funct-decoded
pc_write  output  1  PC write enable
pc_source  output  1  0 = ALU result, 1 = ALUOut
is_halted  output  1  processor halted
retired_count  output  CNT_WIDTH  instructions completed since reset

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Encoding is free.
- Outputs are combinational from state, opcode, bcond and mem_ready (Mealy). Any signal not listed for a state is 0.
- ALUOut, A and B latch every cycle in the datapath. This unit only drives selects and enables.
- Reset asserted (reset=0), at any time, including mid-instruction or in HALT:
  - state <= IF, retired_count <= 0, is_halted <= 0.
  - Every output is forced to 0 while reset is low.
- IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op_sel=00.
  - Stay in IF while mem_ready=0.
  - mem_ready=1: ir_write=1, pc_write=1, pc_source=0 (PC <= PC+4), go to ID.
- ID:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op_sel=00 (ALUOut <= old_pc + imm).
  - ECALL (1110011) with halt_req=1: go to HALT.
  - ECALL with halt_req=0, or any unsupported opcode: retire, go to IF.
  - All other opcodes: go to EX.
- EX, by opcode:
  - R (0110011): A, B, alu_op_sel=10; go to WB.
  - I-arith (0010011): A, imm, alu_op_sel=10; go to WB.
  - LOAD (0000011) / STORE (0100011): A, imm, alu_op_sel=00; go to MEM.
  - BRANCH (1100011): A, B, alu_op_sel=01. If bcond=1: pc_write=1, pc_source=1. Retire, go to IF. If not taken, PC already holds old_pc+4.
  - JAL (1101111): reg_write=1, wd_sel=10, pc_write=1, pc_source=1. Retire, go to IF.
  - JALR (1100111): A, imm, add; reg_write=1, wd_sel=10, pc_write=1, pc_source=0. Retire, go to IF. The register write uses the pre-edge PC, i.e. old_pc+4.
- MEM:
  - Outputs: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE. Hold these while mem_ready=0.
  - On mem_ready=1: LOAD goes to WB; STORE retires and goes to IF.
- WB:
  - Outputs: reg_write=1; wd_sel=01 for LOAD, 00 otherwise.
  - Retire, go to IF.
- HALT:
  - is_halted=1, all enables 0, absorbing until reset.
  - The halting ECALL is not counted.
- Retire means retired_count increments on the same edge as the transition to IF. It wraps modulo 2^CNT_WIDTH.
- mem_ready outside IF/MEM is ignored.
- opcode is sampled only in ID, EX, MEM and WB. IR is stable there.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> state IF, mem_read=1, retired_count=0, is_halted=0. Assert reset=0 mid-MEM -> all outputs 0 immediately.
- add (0110011), mem_ready=1 in the first IF cycle -> 4 cycles IF/ID/EX/WB. reg_write=1 only in WB with wd_sel=00. retired_count 0->1.
- lw, mem_ready low 3 extra cycles in both IF and MEM -> IF 4 cycles, ID, EX, MEM 4 cycles, WB (11 cycles). mem_read held steady. wd_sel=01 in WB.
- beq with bcond=1 -> pc_write=1, pc_source=1 in EX, 3 cycles total. Same with bcond=0 -> pc_write=0 in EX.
- jal then jalr -> each 3 cycles. In EX: reg_write=1, wd_sel=10, pc_write=1; pc_source=1 for jal, 0 for jalr.
- ecall with halt_req=0 -> back to IF after ID, count +1. ecall with halt_req=1 -> HALT, is_halted=1, no output changes for 20 cycles, count unchanged.
